// File: rtl/mth_vcdl_accum_if.sv
// Handshake and data bundle for mth_vcdl_accum.
//   master: the producer/consumer side. It drives the operands (in_valid, a, b, mode, clr)
//           and out_ready.
//   slave : the accumulator side. It drives in_ready, out_valid, sum, carry and ovf_sticky.
interface mth_vcdl_accum_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       mode;
   logic             clr;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             ovf_sticky;

   modport master (
      output in_valid, a, b, mode, clr, out_ready,
      input  in_ready, out_valid, sum, carry, ovf_sticky
   );

   modport slave (
      input  in_valid, a, b, mode, clr, out_ready,
      output in_ready, out_valid, sum, carry, ovf_sticky
   );
endinterface

// File: rtl/mth_vcdl_accum.sv
// mth_vcdl_accum: a registered add/accumulate unit with four selectable modes. It uses
// valid/ready flow control and reports overflow, both per operation and as a sticky flag.
// It accumulates the delay-line codes used for averaging or calibration.
// Ports:
//   clk  - single clock; all state updates on the rising edge
//   rst  - asynchronous, active-high reset
//   bus  - mth_vcdl_accum_if.slave: in_valid/in_ready, a, b, mode, clr,
//          out_valid/out_ready, sum, carry, ovf_sticky
// Modes: 0=ADD_WRAP 1=ADD_SAT 2=ACC_WRAP 3=ACC_SAT. In the ACC modes, sum is the
// upper WIDTH bits of the accumulator.
module mth_vcdl_accum #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned ACC_W = 12
) (
   input  logic                clk,
   input  logic                rst,
   mth_vcdl_accum_if.slave     bus
);

   if (ACC_W < WIDTH + 1) begin : g_bad_acc_w
      $error("mth_vcdl_accum: ACC_W must be >= WIDTH+1");
   end

   typedef enum logic [1:0] {
      ADD_WRAP = 2'd0,
      ADD_SAT  = 2'd1,
      ACC_WRAP = 2'd2,
      ACC_SAT  = 2'd3
   } mode_e;

   logic             out_valid_q;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic             sticky_q;
   logic [ACC_W-1:0] acc_q;

   logic             in_ready;
   logic             accept;
   mode_e            op_mode;
   logic             is_acc;
   logic             is_sat;
   logic [WIDTH:0]   s;
   logic [ACC_W-1:0] base;
   logic [ACC_W:0]   t;
   logic [ACC_W-1:0] acc_nxt;
   logic [WIDTH-1:0] sum_nxt;
   logic             carry_nxt;
   logic             sticky_nxt;

   assign in_ready       = !out_valid_q || bus.out_ready;
   assign accept         = bus.in_valid && in_ready;

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid_q;
   assign bus.sum        = sum_q;
   assign bus.carry      = carry_q;
   assign bus.ovf_sticky = sticky_q;

   always_comb begin
      op_mode    = mode_e'(bus.mode);
      is_acc     = (op_mode == ACC_WRAP) || (op_mode == ACC_SAT);
      is_sat     = (op_mode == ADD_SAT)  || (op_mode == ACC_SAT);
      s          = {1'b0, bus.a} + {1'b0, bus.b};
      // clr zeroes the accumulator in every mode. In the ACC modes this makes the
      // accumulation restart from 0 in the same operation.
      base       = bus.clr ? '0 : acc_q;
      t          = {1'b0, base} + {{(ACC_W - WIDTH){1'b0}}, s};
      acc_nxt    = base;
      carry_nxt  = s[WIDTH];
      sum_nxt    = (is_sat && s[WIDTH]) ? '1 : s[WIDTH-1:0];
      if (is_acc) begin
         carry_nxt = t[ACC_W];
         acc_nxt   = (is_sat && t[ACC_W]) ? '1 : t[ACC_W-1:0];
         sum_nxt   = acc_nxt[ACC_W-1 -: WIDTH];
      end
      // Overflow wins over a same-cycle clr.
      sticky_nxt = (bus.clr ? 1'b0 : sticky_q) | carry_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         sticky_q    <= 1'b0;
         acc_q       <= '0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         sum_q       <= sum_nxt;
         carry_q     <= carry_nxt;
         sticky_q    <= sticky_nxt;
         acc_q       <= acc_nxt;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

endmodule
